// File: rtl/cga_composite_decoder_if.sv
// Composite decoder sample/result bundle.
// master drives samples, slave returns IRGB and syncs.
interface cga_composite_decoder_if;
  logic       ce_14m3;
  logic [6:0] comp_video;
  logic       bw_mode;
  logic [3:0] video_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       burst_lock;
  logic       decode_err;

  modport master (
    output ce_14m3, comp_video, bw_mode,
    input  video_out, hsync_out, vsync_out,
    input  burst_lock, decode_err
  );

  modport slave (
    input  ce_14m3, comp_video, bw_mode,
    output video_out, hsync_out, vsync_out,
    output burst_lock, decode_err
  );
endinterface

// File: rtl/cga_composite_decoder.sv
// CGA composite decoder: sync separation, burst
// lock detection and 4-sample IRGB group decode.
module cga_composite_decoder #(
  parameter int SYNC_THRESH  = 14,
  parameter int VSYNC_MIN    = 64,
  parameter int VSYNC_EXIT   = 128,
  parameter int BURST_START  = 8,
  parameter int BURST_LEN    = 16,
  parameter int BURST_THRESH = 43
) (
  input logic clk,
  input logic reset_n,
  cga_composite_decoder_if.slave bus
);
  localparam logic [6:0] SYNC_T  = 7'(SYNC_THRESH);
  localparam logic [6:0] BURST_T = 7'(BURST_THRESH);
  localparam logic [7:0] VS_MIN  = 8'(VSYNC_MIN);
  localparam logic [7:0] VS_EXIT = 8'(VSYNC_EXIT);
  localparam logic [7:0] WIN_LO  = 8'(BURST_START);
  localparam logic [7:0] WIN_END =
    8'(BURST_START + BURST_LEN - 1);

  logic       sync_det, vs, hs, lock, err;
  logic [7:0] low_run, high_run, since;
  logic [1:0] ph;
  logic [3:0] mask, video;
  logic [6:0] mn, mx;
  logic       gsync, gvalid;

  logic       s, sync_end, vs_nxt, in_win;
  logic       win_end, dec, lock_ok;
  logic [1:0] cur_ph;
  logic [7:0] cur_since, low_nxt, high_nxt;
  logic [3:0] mask_nxt;
  logic [4:0] lut;
  logic [6:0] lvl;

  // {hit, irgb} for the group's minimum level
  function automatic logic [4:0] decode_lvl(
    input logic [6:0] m,
    input logic [6:0] hi,
    input logic       bw
  );
    logic [4:0] r;
    r = 5'h00;
    if (bw) begin
      case (m)
        7'd29:   r = 5'h10;
        7'd64:   r = 5'h11;
        7'd77:   r = 5'h12;
        7'd84:   r = 5'h13;
        7'd67:   r = 5'h14;
        7'd74:   r = 5'h15;
        7'd88:   r = 5'h16;
        7'd96:   r = 5'h17;
        7'd60:   r = 5'h18;
        7'd95:   r = 5'h19;
        7'd108:  r = 5'h1A;
        7'd115:  r = 5'h1B;
        7'd98:   r = 5'h1C;
        7'd105:  r = 5'h1D;
        7'd119:  r = 5'h1E;
        7'd127:  r = 5'h1F;
        default: r = 5'h00;
      endcase
    end else if ((hi - m) >= 7'd20) begin
      case (m)
        7'd36:   r = 5'h11;
        7'd49:   r = 5'h12;
        7'd56:   r = 5'h13;
        7'd39:   r = 5'h14;
        7'd46:   r = 5'h15;
        7'd60:   r = 5'h16;
        7'd67:   r = 5'h19;
        7'd80:   r = 5'h1A;
        7'd87:   r = 5'h1B;
        7'd70:   r = 5'h1C;
        7'd77:   r = 5'h1D;
        7'd91:   r = 5'h1E;
        default: r = 5'h00;
      endcase
    end else begin
      case (m)
        7'd29:   r = 5'h10;
        7'd60:   r = 5'h18;
        7'd96:   r = 5'h17;
        7'd127:  r = 5'h1F;
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    lvl       = bus.comp_video;
    s         = lvl < SYNC_T;
    sync_end  = sync_det & ~s;
    cur_ph    = sync_end ? 2'd0 : ph;
    cur_since = sync_end ? 8'd0 : since;
    low_nxt   = 8'd0;
    high_nxt  = 8'd0;
    if (s)
      low_nxt = (low_run == 8'hFF) ?
                low_run : low_run + 8'd1;
    else
      high_nxt = (high_run == 8'hFF) ?
                 high_run : high_run + 8'd1;
    vs_nxt = vs;
    if (s && low_nxt == VS_MIN)
      vs_nxt = 1'b1;
    else if (!s && high_nxt == VS_EXIT)
      vs_nxt = 1'b0;
    in_win  = (cur_since >= WIN_LO) &&
              (cur_since <= WIN_END);
    win_end = cur_since == WIN_END;
    mask_nxt = sync_end ? 4'd0 : mask;
    if (in_win && lvl >= BURST_T)
      mask_nxt[cur_ph] = 1'b1;
    lock_ok = (mask_nxt == 4'b0011) ||
              (mask_nxt == 4'b0110) ||
              (mask_nxt == 4'b1100) ||
              (mask_nxt == 4'b1001);
    dec = gvalid && (cur_ph == 2'd0);
    lut = decode_lvl(mn, mx, bus.bw_mode);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_det <= 1'b0;
      low_run  <= 8'd0;
      high_run <= 8'd0;
      vs       <= 1'b0;
      hs       <= 1'b0;
      ph       <= 2'd0;
      since    <= 8'd0;
      mask     <= 4'd0;
      lock     <= 1'b0;
      mn       <= 7'd0;
      mx       <= 7'd0;
      gsync    <= 1'b0;
      gvalid   <= 1'b0;
      video    <= 4'd0;
      err      <= 1'b0;
    end else if (bus.ce_14m3) begin
      sync_det <= s;
      low_run  <= low_nxt;
      high_run <= high_nxt;
      vs       <= vs_nxt;
      hs       <= s ^ vs_nxt;
      ph       <= cur_ph + 2'd1;
      since    <= (cur_since == 8'hFF) ?
                  cur_since : cur_since + 8'd1;
      gvalid   <= 1'b1;
      if (cur_ph == 2'd0) begin
        mn    <= lvl;
        mx    <= lvl;
        gsync <= s;
      end else begin
        mn    <= (lvl < mn) ? lvl : mn;
        mx    <= (lvl > mx) ? lvl : mx;
        gsync <= gsync | s;
      end
      if (dec) begin
        if (gsync) begin
          video <= 4'd0;
          err   <= 1'b0;
        end else begin
          video <= lut[4] ? lut[3:0] : 4'd0;
          err   <= ~lut[4];
        end
      end
      // lock holds through vsync; mask still drains
      if (win_end) begin
        mask <= 4'd0;
        if (!vs)
          lock <= lock_ok;
      end else begin
        mask <= mask_nxt;
      end
    end
  end

  assign bus.video_out  = video;
  assign bus.hsync_out  = hs;
  assign bus.vsync_out  = vs;
  assign bus.burst_lock = lock;
  assign bus.decode_err = err;
endmodule

// File: tb/tb_cga_composite_decoder.sv
// Bench for the CGA composite decoder: vectors,
// hand sequences and random lines against a model.
module tb_cga_composite_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cga_composite_decoder_if bus ();

  cga_composite_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  int lv  [8192];
  bit sy  [8192];
  int phv [8192];
  int n = 0;
  int last_end = -1;
  int last_g = -1;
  logic [3:0] e_vid;
  logic e_hs, e_vs, e_lock, e_err;

  typedef struct {
    int         p [4];
    bit         bw;
    logic [3:0] vid;
    bit         err;
  } vec_t;

  task automatic check(string name,
                       logic [7:0] act,
                       logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // {err, irgb} from the level tables
  function automatic logic [4:0] ref_dec(
    int mn, int mx, bit bw);
    int bwl [8] = '{29, 64, 77, 84, 67, 74, 88, 96};
    int csw [6] = '{36, 49, 56, 39, 46, 60};
    if (bw) begin
      for (int i = 0; i < 8; i++) begin
        if (mn == bwl[i]) return {2'b00, 3'(i)};
        if (mn == bwl[i] + 31) return {2'b01, 3'(i)};
      end
    end else if (mx - mn >= 20) begin
      for (int i = 0; i < 6; i++) begin
        if (mn == csw[i]) return {2'b00, 3'(i + 1)};
        if (mn == csw[i] + 31)
          return {2'b01, 3'(i + 1)};
      end
    end else begin
      if (mn == 29)  return 5'b00000;
      if (mn == 60)  return 5'b01000;
      if (mn == 96)  return 5'b00111;
      if (mn == 127) return 5'b01111;
    end
    return 5'b10000;
  endfunction

  task automatic model_reset();
    n = 0;
    last_end = -1;
    last_g = -1;
    e_vid = 4'd0;
    e_hs = 1'b0;
    e_vs = 1'b0;
    e_lock = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic model_step(int l, bit bw);
    int k, run, ph, since, mn, mx, mask;
    bit s, gs, prev_vs;
    logic [4:0] r;
    k = n;
    if (k >= 8192) begin
      $display("FAIL model_overflow: got %0d", k);
      $fatal(1);
    end
    s = l < 14;
    lv[k] = l;
    sy[k] = s;
    if (k > 0 && sy[k-1] && !s) last_end = k;
    since = (last_end < 0) ? k : k - last_end;
    ph = since % 4;
    if (since > 255) since = 255;
    phv[k] = ph;
    run = 0;
    for (int j = k; j >= 0; j--) begin
      if (sy[j] != s || run == 255) break;
      run++;
    end
    prev_vs = e_vs;
    if (s && run == 64) e_vs = 1'b1;
    else if (!s && run == 128) e_vs = 1'b0;
    e_hs = s ^ e_vs;
    if (ph == 0 && k > 0) begin
      mn = 999; mx = -1; gs = 1'b0;
      for (int j = last_g; j < k; j++) begin
        if (lv[j] < mn) mn = lv[j];
        if (lv[j] > mx) mx = lv[j];
        gs |= sy[j];
      end
      if (gs) begin
        e_vid = 4'd0;
        e_err = 1'b0;
      end else begin
        r = ref_dec(mn, mx, bw);
        e_err = r[4];
        e_vid = r[3:0];
      end
    end
    if (ph == 0) last_g = k;
    if (since == 23 && !prev_vs) begin
      mask = 0;
      for (int j = k - 15; j <= k; j++)
        if (lv[j] >= 43) mask |= 1 << phv[j];
      e_lock = (mask == 3) || (mask == 6) ||
               (mask == 12) || (mask == 9);
    end
    n++;
  endtask

  task automatic samp(int l, bit bw);
    @(negedge clk);
    bus.comp_video = 7'(l);
    bus.bw_mode = bw;
    bus.ce_14m3 = 1'b1;
    @(negedge clk);
    bus.ce_14m3 = 1'b0;
    model_step(l, bw);
    tests++;
    if ({bus.video_out, bus.hsync_out,
         bus.vsync_out, bus.burst_lock,
         bus.decode_err} !==
        {e_vid, e_hs, e_vs, e_lock, e_err}) begin
      fails++;
      $display("FAIL model@%0d: got v%h h%b vs%b l%b e%b expected v%h h%b vs%b l%b e%b",
               n - 1, bus.video_out, bus.hsync_out,
               bus.vsync_out, bus.burst_lock,
               bus.decode_err, e_vid, e_hs, e_vs,
               e_lock, e_err);
    end
  endtask

  task automatic run(int l, int cnt, bit bw);
    for (int i = 0; i < cnt; i++) samp(l, bw);
  endtask

  task automatic do_reset(int cycles, string name);
    @(negedge clk);
    reset_n = 1'b0;
    bus.ce_14m3 = 1'b1;
    repeat (cycles) @(negedge clk);
    check({name, "_outs"},
          {bus.video_out, bus.hsync_out,
           bus.vsync_out, bus.burst_lock,
           bus.decode_err}, 8'h00);
    reset_n = 1'b1;
    bus.ce_14m3 = 1'b0;
    model_reset();
  endtask

  task automatic burst_line(int blen, bit good);
    run(0, 6, 1'b0);
    run(29, 8, 1'b0);
    for (int i = 0; i < blen; i++)
      samp((good && (i % 4) < 2) ? 57 : 29, 1'b0);
  endtask

  vec_t vt [12];
  int pal [20] = '{29, 60, 96, 127, 36, 49, 56, 39,
                   46, 67, 80, 64, 77, 84, 74, 88,
                   98, 105, 119, 57};

  initial begin
    bus.ce_14m3 = 1'b0;
    bus.comp_video = 7'd127;
    bus.bw_mode = 1'b0;
    model_reset();

    vt[0]  = '{'{39, 39, 67, 67},   0, 4'h4, 0};
    vt[1]  = '{'{127, 127, 127, 127}, 0, 4'hF, 0};
    vt[2]  = '{'{29, 29, 29, 29},   0, 4'h0, 0};
    vt[3]  = '{'{98, 98, 98, 98},   1, 4'hC, 0};
    vt[4]  = '{'{50, 50, 50, 50},   1, 4'h0, 1};
    vt[5]  = '{'{60, 60, 60, 60},   0, 4'h8, 0};
    vt[6]  = '{'{96, 96, 96, 96},   0, 4'h7, 0};
    vt[7]  = '{'{67, 67, 98, 98},   0, 4'h9, 0};
    vt[8]  = '{'{36, 60, 36, 60},   0, 4'h1, 0};
    vt[9]  = '{'{45, 45, 45, 45},   0, 4'h0, 1};
    vt[10] = '{'{64, 64, 64, 64},   1, 4'h1, 0};
    vt[11] = '{'{46, 46, 46, 46},   0, 4'h0, 1};

    do_reset(4, "reset");
    samp(127, 1'b0);
    check("reset_hsync", {7'd0, bus.hsync_out}, 8'd0);

    foreach (vt[v]) begin
      run(0, 4, vt[v].bw);
      for (int g = 0; g < 3; g++)
        for (int i = 0; i < 4; i++)
          samp(vt[v].p[i], vt[v].bw);
      check($sformatf("vec%0d_video", v),
            {4'd0, bus.video_out}, {4'd0, vt[v].vid});
      check($sformatf("vec%0d_err", v),
            {7'd0, bus.decode_err}, {7'd0, vt[v].err});
    end

    burst_line(16, 1'b1);
    check("burst_lock_on", {7'd0, bus.burst_lock}, 8'd1);
    burst_line(16, 1'b0);
    check("burst_lock_off", {7'd0, bus.burst_lock}, 8'd0);

    run(0, 63, 1'b0);
    check("vsync_pre", {7'd0, bus.vsync_out}, 8'd0);
    samp(0, 1'b0);
    check("vsync_set", {7'd0, bus.vsync_out}, 8'd1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        samp(29, 1'b0);
        check("serr_hsync", {7'd0, bus.hsync_out}, 8'd1);
      end
      run(0, 56, 1'b0);
      check("serr_vsync", {7'd0, bus.vsync_out}, 8'd1);
    end
    run(29, 127, 1'b0);
    check("vsync_hold", {7'd0, bus.vsync_out}, 8'd1);
    samp(29, 1'b0);
    check("vsync_clr", {7'd0, bus.vsync_out}, 8'd0);

    run(0, 70, 1'b0);
    check("mid_vsync", {7'd0, bus.vsync_out}, 8'd1);
    do_reset(2, "rst_vsync");
    burst_line(16, 1'b1);
    check("pre_rst_lock", {7'd0, bus.burst_lock}, 8'd1);
    burst_line(8, 1'b1);
    do_reset(2, "rst_burst");
    run(0, 4, 1'b0);
    for (int g = 0; g < 3; g++) begin
      samp(39, 1'b0); samp(39, 1'b0);
      samp(67, 1'b0); samp(67, 1'b0);
    end
    check("post_rst_video", {4'd0, bus.video_out}, 8'h04);
    burst_line(16, 1'b1);
    check("post_rst_lock", {7'd0, bus.burst_lock}, 8'd1);

    do_reset(2, "rst_rand");
    for (int seg = 0; seg < 30; seg++) begin
      bit bw;
      int sl, al, p, q, m;
      bw = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 5) == 0) ?
           $urandom_range(60, 80) : $urandom_range(1, 8);
      for (int i = 0; i < sl; i++)
        samp($urandom_range(0, 13), bw);
      al = ($urandom_range(0, 5) == 0) ?
           $urandom_range(120, 140) : $urandom_range(20, 60);
      for (int i = 0; i < al; i += 4) begin
        p = pal[$urandom_range(0, 19)];
        q = pal[$urandom_range(0, 19)];
        m = $urandom_range(0, 2);
        for (int j = 0; j < 4; j++) begin
          if (m == 0) samp(p, bw);
          else if (m == 1) samp(j < 2 ? p : q, bw);
          else samp($urandom_range(14, 127), bw);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
